// File: rtl/npc_pkg.sv
// Shared npc core types: IFU FSM states, reset fetch address and the canonical NOP.
// Pure declarations; no latency or flow control of its own.
package npc_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifu_perf.sv
// IFU performance counters: decode transfers and fetch-stall cycles, updated every cycle.
// Free-running, never backpressures; counters wrap at 2^32.
module ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch: one outstanding imem read, word held for decode; request to out_valid 2 cycles.
// Holds the word until out_ready; redirects override everything. IFU_PERF_EN adds perf counters.
module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  ifu_state_t  state, state_nxt;
  logic        kill, kill_nxt;
  logic [31:0] fetch_pc;
  logic        take_resp;
  logic        xfer;
  logic        stall_cyc;
  logic        unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  assign take_resp = (state == S_WAIT) && imem_resp_valid && !kill && !redirect_valid;
  assign xfer      = (state == S_HOLD) && out_ready && !redirect_valid;
  assign stall_cyc = (state == S_REQ) || (state == S_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
    end
  end

  // kill marks an in-flight response for an abandoned PC; it drains exactly one response.
  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    case (state)
      S_REQ: begin
        if (imem_req_ready) begin
          state_nxt = S_WAIT;
          kill_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          kill_nxt  = 1'b0;
          state_nxt = (kill || redirect_valid) ? S_REQ : S_HOLD;
        end else if (redirect_valid) begin
          kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || out_ready) state_nxt = S_REQ;
      end
      default: begin
        state_nxt = S_REQ;
        kill_nxt  = 1'b0;
      end
    endcase
  end

  // Request valid is masked by rst so nothing is offered while the core is held in reset.
  always_comb begin
    imem_req_valid = (state == S_REQ) && !rst;
    out_valid      = (state == S_HOLD);
  end

  assign imem_req_addr = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      out_pc   <= 32'd0;
      out_inst <= 32'd0;
    end else begin
      if (redirect_valid) fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (xfer)      fetch_pc <= pc_next(fetch_pc);
      if (take_resp) begin
        out_pc   <= fetch_pc;
        out_inst <= imem_resp_data;
      end
    end
  end

`ifdef IFU_PERF_EN
  ifu_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (xfer),
    .stall_inc (stall_cyc),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf = stall_cyc;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu with a behavioural instruction memory and an expected-PC queue.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [31:0] exp_q[$];

  int          resp_delay = 1;
  logic        override = 1'b0;
  logic [31:0] override_data = 32'h0;
  int          mem_cnt = 0;
  logic        mem_hs;
  logic [31:0] mem_a;
  logic [31:0] mem_pend = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory: responds resp_delay cycles after the handshake edge (1 = the very next cycle).
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      mem_hs = imem_req_valid && imem_req_ready && !rst;
      mem_a  = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst) begin
        mem_cnt = 0;
      end else begin
        if (mem_hs) begin
          mem_cnt  = resp_delay;
          mem_pend = mem_a;
        end
        if (mem_cnt > 0) begin
          mem_cnt = mem_cnt - 1;
          if (mem_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = override ? override_data : mem_word(mem_pend);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    cyc = cyc + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input string tag);
    int          n;
    logic [31:0] e;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n = n + 1;
    end
    check1({tag, "_valid"}, out_valid, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
    check({tag, "_pc"}, out_pc, e);
    check({tag, "_inst"}, out_inst, mem_word(e));
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    step();
    step();
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    rst = 1'b0;
    cyc = 0;
    #1;
    check1("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, 32'h8000_0000);

    // Zero-wait stream: one instruction every 3 cycles.
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h8000_0000 + 32'(4 * i));
    wait_out("seq0");
    check("seq0_latency", 32'(cyc), 32'd2);
    t0 = cyc;
    step();
    wait_out("seq1");
    check("seq1_gap", 32'(cyc - t0), 32'd3);
    t0 = cyc;
    step();
    wait_out("seq2");
    check("seq2_gap", 32'(cyc - t0), 32'd3);
    step();

    // Decode stall in S_HOLD.
    out_ready = 1'b0;
    exp_q.push_back(32'h8000_000C);
    wait_out("stall");
    for (int k = 0; k < 5; k++) begin
      step();
      check1("stall_valid", out_valid, 1'b1);
      check("stall_pc", out_pc, 32'h8000_000C);
      check("stall_inst", out_inst, mem_word(32'h8000_000C));
      check1("stall_no_req", imem_req_valid, 1'b0);
    end
    out_ready = 1'b1;
    step();
    check1("stall_done_req", imem_req_valid, 1'b1);
    check("stall_done_addr", imem_req_addr, 32'h8000_0010);

    // Redirect in S_WAIT; the late response must be dropped.
    resp_delay    = 3;
    override      = 1'b1;
    override_data = 32'hDEAD_BEEF;
    step();
    check1("wait_no_req", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0101;
    step();
    redirect_valid = 1'b0;
    check1("kill_no_out0", out_valid, 1'b0);
    check1("kill_no_req0", imem_req_valid, 1'b0);
    step();
    check1("kill_no_out1", out_valid, 1'b0);
    resp_delay = 1;
    override   = 1'b0;
    step();
    check1("drop_out_valid", out_valid, 1'b0);
    check1("drop_req_valid", imem_req_valid, 1'b1);
    check("drop_req_addr", imem_req_addr, 32'h8000_0100);
    exp_q.push_back(32'h8000_0100);
    wait_out("redir_wait");
    step();

    // Redirect in S_HOLD with out_ready high: held word discarded.
    exp_q.push_back(32'h8000_0104);
    wait_out("pre_hold");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    check1("hold_redir_out", out_valid, 1'b0);
    check1("hold_redir_req", imem_req_valid, 1'b1);
    check("hold_redir_addr", imem_req_addr, 32'h8000_0200);
    exp_q.push_back(32'h8000_0200);
    wait_out("redir_hold");
    step();

    // Memory not ready: request held steady.
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check1("busy_req_valid", imem_req_valid, 1'b1);
      check("busy_req_addr", imem_req_addr, 32'h8000_0204);
    end
    imem_req_ready = 1'b1;
    step();
    check1("busy_wait", imem_req_valid, 1'b0);

    // Reset while waiting for a response.
    rst = 1'b1;
    #1;
    check1("mid_rst_req", imem_req_valid, 1'b0);
    check1("mid_rst_out", out_valid, 1'b0);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_inst", out_inst, 32'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    check1("post_mid_rst_req", imem_req_valid, 1'b1);
    check("post_mid_rst_addr", imem_req_addr, 32'h8000_0000);
    exp_q.push_back(32'h8000_0000);
    wait_out("after_rst");

    // PC wrap at the top of the address space; low bits of redirect ignored.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    check("top_addr", imem_req_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    wait_out("top");
    step();
    check("wrap_addr", imem_req_addr, 32'h0);
    exp_q.push_back(32'h0);
    wait_out("wrap");
    step();

    // Ten zero-wait transfers from a fresh reset.
    rst = 1'b1;
    step();
`ifdef IFU_PERF_EN
    check("perf_rst_fetch", perf_fetch_cnt, 32'd0);
    check("perf_rst_stall", perf_stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(32'h8000_0000 + 32'(4 * i));
      wait_out("run10");
      step();
    end
`ifdef IFU_PERF_EN
    check("perf_fetch", perf_fetch_cnt, 32'd10);
    check("perf_stall", perf_stall_cnt, 32'd20);
`endif
    check("run10_next_addr", imem_req_addr, 32'h8000_0028);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
